time_report_scheduler: RTL and testbench
========================================

Name: time_report_scheduler

Overview:
- Sequences the UART transmit path to send the current watch/stopwatch time as an ASCII frame, "HH:MM:SS.CC\r\n", on request.
- Sits between the watch datapath (time fields) and the UART transmitter's byte interface (tx_start/tx_data/tx_busy/tx_done).
- Requests come from a single-cycle pulse, e.g. a decoded UART command or a debounced button.

Parameters:
- EN_CS, 1: 1 = send ".CC" centisecond field (13-byte frame); 0 = omit it (10-byte frame).
- TIMEOUT, 1000000: max clk cycles to wait for tx_done after a tx_start before aborting the frame.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- req  input  1  single-cycle report request
- hour  input  5  hours 0-23
- min  input  6  minutes 0-59
- sec  input  6  seconds 0-59
- cs  input  7  centiseconds 0-99
- tx_busy  input  1  transmitter busy
- tx_done  input  1  single-cycle pulse when a byte finishes
- tx_start  output  1  single-cycle byte launch strobe
- tx_data  output  8  byte to send; valid while tx_start is high
- busy  output  1  frame in progress
- frame_done  output  1  single-cycle pulse after the last byte's tx_done
- err  output  1  single-cycle pulse on timeout abort

Behaviour:
- All state is updated on posedge clk. reset==0 forces the FSM to IDLE and clears the pending flag, byte index, timer, tx_start, tx_data (0x00), busy, frame_done and err. Reset mid-frame abandons the frame immediately.
- FSM states: IDLE, LOAD, ISSUE, WAIT, NEXT.
- IDLE -> LOAD: on req, or when the pending flag is set.
- LOAD (1 cycle):
  - Snapshots hour/min/sec/cs into internal registers and converts each to two ASCII digits (tens = v/10, ones = v%10, plus 0x30).
  - Sets busy=1, sets byte index=0 and clears pending.
  - Inputs changing after LOAD do not affect the frame.
- ISSUE:
  - Stays in ISSUE while tx_busy==1.
  - When tx_busy==0, drives tx_start=1 for exactly one cycle with tx_data = byte[index], loads the timer to 0, and goes to WAIT.
- WAIT:
  - On tx_done, goes to NEXT.
  - If no tx_done arrives by timer == TIMEOUT-1: pulses err, sets busy=0, goes to IDLE, and discards the pending flag.
- NEXT:
  - If index == LAST: pulses frame_done, sets busy=0, goes to IDLE.
  - Otherwise increments index and goes to ISSUE.
- Byte order:
  - EN_CS=1: H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 0x0D 0x0A (LAST=12).
  - EN_CS=0: the first 8 bytes, then 0x0D 0x0A (LAST=9).
- req while busy:
  - Sets pending (one-deep). Further reqs while pending is set are dropped.
  - The pending frame starts 1 cycle after frame_done and re-snapshots the time at its own LOAD.
- A req in the same cycle as frame_done counts as pending.
- Out-of-range field values (e.g. hour>23) are still converted using /10 and %10; digits above 9 are sent unchanged (0x30+digit). No saturation.
- tx_data holds its last value between strobes.
- Latency: req to first tx_start = 2 cycles when tx_busy==0.

Test Plan:
- Basic frame: hour=12, min=34, sec=56, cs=78, one req, transmitter model pulses tx_done 20 cycles after each start -> 13 starts with bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A; frame_done once; busy low after; first tx_start 2 cycles after req.
- Snapshot: change hour to 23 during byte 5 -> frame still carries "12"; a second req during the frame -> second frame follows automatically and carries "23"; a third req during the same frame is ignored (exactly 2 frames total).
- tx_busy held high 50 cycles before the first byte -> no tx_start until tx_busy falls, then the normal sequence.
- Timeout with TIMEOUT=100: tx_done withheld after byte 3 -> err pulses exactly 100 cycles after that tx_start, busy=0, FSM returns to IDLE, no frame_done; the next req sends a full frame.
- Reset: reset=0 asserted during byte 7 -> next cycle busy=0, tx_start=0, tx_data=0x00, pending cleared; no further bytes are sent.
- EN_CS=0 instance: 00:00:09 -> bytes 30 30 3A 30 30 3A 30 39 0D 0A, then frame_done.

Source files
------------

// File: rtl/time_report_scheduler_if.sv
// Byte-level link between the time report scheduler, the watch datapath
// (time fields, request) and the UART transmitter (tx_* handshake).
//   req                  single-cycle report request
//   hour/min/sec/cs      current time fields
//   tx_busy/tx_done      transmitter status and per-byte completion pulse
//   tx_start/tx_data     byte launch strobe and byte value
//   busy/frame_done/err  frame status towards the requester
// The scheduler attaches through the slave modport; its environment uses master.
interface time_report_scheduler_if;
    logic       req;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       err;

    modport master (
        output req, hour, min, sec, cs, tx_busy, tx_done,
        input  tx_start, tx_data, busy, frame_done, err
    );

    modport slave (
        input  req, hour, min, sec, cs, tx_busy, tx_done,
        output tx_start, tx_data, busy, frame_done, err
    );
endinterface

// File: rtl/time_report_scheduler.sv
// Sends the current time as "HH:MM:SS.CC\r\n" (or "HH:MM:SS\r\n" when EN_CS=0)
// through a byte-oriented UART transmitter, one byte per tx_start/tx_done pair.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   link   slave side of time_report_scheduler_if (request, time fields,
//          transmitter handshake, busy/frame_done/err status)
// A request that arrives while a frame is running queues exactly one follow-up
// frame, which re-samples the time when it starts. A byte whose tx_done does
// not arrive within TIMEOUT cycles aborts the frame with an err pulse.
module time_report_scheduler #(
    parameter bit          EN_CS   = 1'b1,
    parameter int unsigned TIMEOUT = 1000000
) (
    input logic                    clk,
    input logic                    reset,
    time_report_scheduler_if.slave link
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = EN_CS ? IDX_W'(12) : IDX_W'(9);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]       state,   state_nxt;
    logic             pending, pending_nxt;
    logic [IDX_W-1:0] idx,     idx_nxt;
    logic [TMR_W-1:0] timer,   timer_nxt;
    logic [4:0]       hour_q,  hour_nxt;
    logic [5:0]       min_q,   min_nxt;
    logic [5:0]       sec_q,   sec_nxt;
    logic [6:0]       cs_q,    cs_nxt;
    logic             start_q, start_nxt;
    logic [7:0]       data_q,  data_nxt;
    logic             busy_q,  busy_nxt;
    logic             done_q,  done_nxt;
    logic             err_q,   err_nxt;
    logic [7:0]       cur_byte;

    function automatic logic [7:0] tens_ascii(input logic [6:0] v);
        return 8'h30 + 8'(v / 7'd10);
    endfunction

    function automatic logic [7:0] ones_ascii(input logic [6:0] v);
        return 8'h30 + 8'(v % 7'd10);
    endfunction

    // Byte at the current frame position, built from the LOAD-time snapshot.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            IDX_W'(0):  cur_byte = tens_ascii(7'(hour_q));
            IDX_W'(1):  cur_byte = ones_ascii(7'(hour_q));
            IDX_W'(2):  cur_byte = 8'h3A;
            IDX_W'(3):  cur_byte = tens_ascii(7'(min_q));
            IDX_W'(4):  cur_byte = ones_ascii(7'(min_q));
            IDX_W'(5):  cur_byte = 8'h3A;
            IDX_W'(6):  cur_byte = tens_ascii(7'(sec_q));
            IDX_W'(7):  cur_byte = ones_ascii(7'(sec_q));
            IDX_W'(8):  cur_byte = EN_CS ? 8'h2E : 8'h0D;
            IDX_W'(9):  cur_byte = EN_CS ? tens_ascii(cs_q) : 8'h0A;
            IDX_W'(10): cur_byte = ones_ascii(cs_q);
            IDX_W'(11): cur_byte = 8'h0D;
            IDX_W'(12): cur_byte = 8'h0A;
            default:    cur_byte = 8'h00;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        idx_nxt     = idx;
        timer_nxt   = timer;
        hour_nxt    = hour_q;
        min_nxt     = min_q;
        sec_nxt     = sec_q;
        cs_nxt      = cs_q;
        start_nxt   = 1'b0;
        data_nxt    = data_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        if (link.req && (state != S_IDLE)) begin
            pending_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (link.req || pending) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                hour_nxt    = link.hour;
                min_nxt     = link.min;
                sec_nxt     = link.sec;
                cs_nxt      = link.cs;
                // The queued request is consumed here; a request landing on
                // this very cycle queues the next frame instead of being lost.
                pending_nxt = link.req;
                busy_nxt    = 1'b1;
                idx_nxt     = '0;
                state_nxt   = S_ISSUE;
            end
            S_ISSUE: begin
                if (!link.tx_busy) begin
                    start_nxt = 1'b1;
                    data_nxt  = cur_byte;
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (link.tx_done) begin
                    state_nxt = S_NEXT;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    err_nxt     = 1'b1;
                    busy_nxt    = 1'b0;
                    pending_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_NEXT: begin
                if (idx == IDX_LAST) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            idx     <= '0;
            timer   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            cs_q    <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            idx     <= idx_nxt;
            timer   <= timer_nxt;
            hour_q  <= hour_nxt;
            min_q   <= min_nxt;
            sec_q   <= sec_nxt;
            cs_q    <= cs_nxt;
            start_q <= start_nxt;
            data_q  <= data_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
        end
    end

    assign link.tx_start   = start_q;
    assign link.tx_data    = data_q;
    assign link.busy       = busy_q;
    assign link.frame_done = done_q;
    assign link.err        = err_q;
endmodule

// File: tb/tb_time_report_scheduler.sv
// Bench for time_report_scheduler: one EN_CS=1 and one EN_CS=0 instance share
// the request/time/tx_busy stimulus; each has its own transmitter model that
// answers tx_start with a delayed tx_done pulse (or withholds it).
module tb_time_report_scheduler;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    time_report_scheduler_if if0 ();
    time_report_scheduler_if if1 ();

    time_report_scheduler #(.EN_CS(1'b1), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(reset), .link(if0.slave));
    time_report_scheduler #(.EN_CS(1'b0), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .reset(reset), .link(if1.slave));

    int n_pass   = 0;
    int n_checks = 0;
    int edge_n   = 0;
    int req_edge = 0;

    // shared stimulus
    logic       s_req;
    logic [4:0] s_hour;
    logic [5:0] s_min;
    logic [5:0] s_sec;
    logic [6:0] s_cs;
    logic       s_busy;
    logic       s_done [2];

    // transmitter models
    int done_dly  = 20;
    bit rand_dly  = 1'b0;
    bit rand_drop = 1'b0;
    int d_cnt       [2];
    int withhold_at [2];

    // observation logs
    byte unsigned cap0[$];
    byte unsigned cap1[$];
    int fd_cnt [2];
    int err_cnt [2];
    int start_cnt [2];
    int first_start_edge [2];
    int last_start_edge [2];
    int err_edge [2];

    // reference model: frame contents plus progress through it
    byte unsigned m_frame [2][13];
    int m_len  [2];
    int m_sent [2];
    int m_age  [2];
    bit m_loading [2];
    bit m_active [2];
    bit m_ready [2];
    bit m_inflight [2];
    bit m_gap [2];
    bit m_pend [2];
    bit e_start [2];
    bit e_fd [2];
    bit e_err [2];
    byte unsigned e_data [2];

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at edge %0d",
                      name, got, got, exp, exp, edge_n);
    endtask

    // ASCII frame from field values: two decimal digits per field, separators, CR LF.
    function automatic void build_frame(input int i, input int h, input int mi,
                                        input int s, input int c);
        int f[4];
        int k;
        int nf;
        f[0] = h; f[1] = mi; f[2] = s; f[3] = c;
        nf = (i == 0) ? 4 : 3;
        k = 0;
        for (int j = 0; j < nf; j++) begin
            if (j > 0) begin
                m_frame[i][k] = (j == 3) ? 8'h2E : 8'h3A;
                k++;
            end
            m_frame[i][k] = 8'(48 + f[j] / 10); k++;
            m_frame[i][k] = 8'(48 + f[j] % 10); k++;
        end
        m_frame[i][k]     = 8'h0D;
        m_frame[i][k + 1] = 8'h0A;
        m_len[i] = k + 2;
    endfunction

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            e_start[i] = 1'b0;
            e_fd[i]    = 1'b0;
            e_err[i]   = 1'b0;
            if (!reset) begin
                m_loading[i] = 0; m_active[i] = 0; m_ready[i] = 0;
                m_inflight[i] = 0; m_gap[i] = 0; m_pend[i] = 0;
                e_data[i] = 8'h00;
            end else if (m_loading[i]) begin
                build_frame(i, int'(s_hour), int'(s_min), int'(s_sec), int'(s_cs));
                m_loading[i] = 0;
                m_active[i]  = 1;
                m_ready[i]   = 1;
                m_sent[i]    = 0;
                m_pend[i]    = s_req;
            end else if (!m_active[i]) begin
                if (s_req || m_pend[i]) m_loading[i] = 1;
            end else begin
                if (s_req) m_pend[i] = 1;
                if (m_ready[i]) begin
                    if (!s_busy) begin
                        e_start[i] = 1;
                        e_data[i]  = m_frame[i][m_sent[i]];
                        m_ready[i] = 0;
                        m_inflight[i] = 1;
                        m_age[i] = 0;
                    end
                end else if (m_inflight[i]) begin
                    if (s_done[i]) begin
                        m_inflight[i] = 0;
                        m_gap[i] = 1;
                    end else if (m_age[i] == TMO - 1) begin
                        e_err[i] = 1;
                        m_inflight[i] = 0;
                        m_active[i] = 0;
                        m_pend[i] = 0;
                    end else begin
                        m_age[i]++;
                    end
                end else if (m_gap[i]) begin
                    m_gap[i] = 0;
                    m_sent[i]++;
                    if (m_sent[i] == m_len[i]) begin
                        e_fd[i] = 1;
                        m_active[i] = 0;
                    end else begin
                        m_ready[i] = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, step model at posedge, compare/observe at negedge.
    task automatic cycle();
        logic       o_start [2];
        logic [7:0] o_data [2];
        logic       o_busy [2];
        logic       o_fd [2];
        logic       o_err [2];
        if0.req = s_req; if1.req = s_req;
        if0.hour = s_hour; if1.hour = s_hour;
        if0.min = s_min; if1.min = s_min;
        if0.sec = s_sec; if1.sec = s_sec;
        if0.cs = s_cs; if1.cs = s_cs;
        if0.tx_busy = s_busy; if1.tx_busy = s_busy;
        if0.tx_done = s_done[0]; if1.tx_done = s_done[1];
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
        o_start[0] = if0.tx_start; o_data[0] = if0.tx_data; o_busy[0] = if0.busy;
        o_fd[0] = if0.frame_done; o_err[0] = if0.err;
        o_start[1] = if1.tx_start; o_data[1] = if1.tx_data; o_busy[1] = if1.busy;
        o_fd[1] = if1.frame_done; o_err[1] = if1.err;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx_start%0d", i), int'(o_start[i]), int'(e_start[i]));
            chk($sformatf("tx_data%0d", i), int'(o_data[i]), int'(e_data[i]));
            chk($sformatf("busy%0d", i), int'(o_busy[i]), int'(m_active[i]));
            chk($sformatf("frame_done%0d", i), int'(o_fd[i]), int'(e_fd[i]));
            chk($sformatf("err%0d", i), int'(o_err[i]), int'(e_err[i]));
            if (o_fd[i]) fd_cnt[i]++;
            if (o_err[i]) begin
                err_cnt[i]++;
                err_edge[i] = edge_n;
            end
            s_done[i] = 1'b0;
            if (!reset) begin
                d_cnt[i] = 0;
            end else if (o_start[i]) begin
                start_cnt[i]++;
                if (i == 0) cap0.push_back(o_data[i]);
                else        cap1.push_back(o_data[i]);
                if (start_cnt[i] == 1) first_start_edge[i] = edge_n;
                last_start_edge[i] = edge_n;
                if (withhold_at[i] == start_cnt[i] || (rand_drop && $urandom_range(0, 39) == 0))
                    d_cnt[i] = 0;
                else
                    d_cnt[i] = rand_dly ? int'($urandom_range(1, 8)) : done_dly;
            end else if (d_cnt[i] > 0) begin
                d_cnt[i]--;
                if (d_cnt[i] == 0) s_done[i] = 1'b1;
            end
        end
    endtask

    task automatic clear_logs();
        cap0.delete();
        cap1.delete();
        for (int i = 0; i < 2; i++) begin
            fd_cnt[i] = 0; err_cnt[i] = 0; start_cnt[i] = 0;
            first_start_edge[i] = -1; last_start_edge[i] = -1; err_edge[i] = -1;
        end
    endtask

    task automatic pulse_req();
        s_req = 1'b1;
        cycle();
        req_edge = edge_n;
        s_req = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int n, input int limit);
        for (int k = 0; k < limit && !(fd_cnt[0] >= n && fd_cnt[1] >= n); k++) cycle();
        chk({name, "_frames0"}, fd_cnt[0], n);
        chk({name, "_frames1"}, fd_cnt[1], n);
    endtask

    task automatic chk_bytes(input string name, input byte unsigned got[$],
                             input byte unsigned exp[$], input int base, input int total);
        chk({name, "_len"}, got.size(), total);
        for (int j = 0; j < exp.size(); j++)
            if (base + j < got.size())
                chk($sformatf("%s_b%0d", name, base + j), int'(got[base + j]), int'(exp[j]));
    endtask

    initial begin
        byte unsigned exp_a[$];
        byte unsigned exp_b[$];
        byte unsigned exp_12[$];
        byte unsigned exp_23[$];

        exp_a  = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                   8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        exp_b  = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                   8'h0D, 8'h0A};
        exp_12 = '{8'h31, 8'h32};
        exp_23 = '{8'h32, 8'h33};

        reset = 1'b0;
        s_req = 1'b0; s_hour = '0; s_min = '0; s_sec = '0; s_cs = '0; s_busy = 1'b0;
        s_done[0] = 1'b0; s_done[1] = 1'b0;
        d_cnt[0] = 0; d_cnt[1] = 0;
        withhold_at[0] = 0; withhold_at[1] = 0;
        clear_logs();

        // reset state
        repeat (3) cycle();
        chk("rst_busy0", int'(if0.busy), 0);
        chk("rst_data0", int'(if0.tx_data), 0);
        chk("rst_start1", int'(if1.tx_start), 0);
        reset = 1'b1;
        cycle();

        // basic frame and request latency
        s_hour = 5'd12; s_min = 6'd34; s_sec = 6'd56; s_cs = 7'd78;
        clear_logs();
        pulse_req();
        wait_frames("basic", 1, 1500);
        chk_bytes("basic0", cap0, exp_a, 0, 13);
        chk_bytes("basic1", cap1, exp_b, 0, 10);
        chk("basic_latency", first_start_edge[0] - req_edge, 2);
        cycle();
        chk("basic_busy_after", int'(if0.busy), 0);

        // snapshot, one queued follow-up frame, extra request dropped
        clear_logs();
        pulse_req();
        for (int k = 0; k < 1000 && start_cnt[0] < 5; k++) cycle();
        s_hour = 5'd23;
        pulse_req();
        repeat (10) cycle();
        pulse_req();
        wait_frames("snap", 2, 2500);
        repeat (200) cycle();
        chk("snap_total0", fd_cnt[0], 2);
        chk_bytes("snap0a", cap0, exp_12, 0, 26);
        chk_bytes("snap0b", cap0, exp_23, 13, 26);
        chk_bytes("snap1b", cap1, exp_23, 10, 20);

        // transmitter busy before the first byte
        s_hour = 5'd12;
        s_busy = 1'b1;
        clear_logs();
        pulse_req();
        repeat (49) cycle();
        chk("hold_no_start", start_cnt[0] + start_cnt[1], 0);
        s_busy = 1'b0;
        wait_frames("hold", 1, 1500);
        chk_bytes("hold0", cap0, exp_a, 0, 13);
        chk("hold_first_edge", int'(first_start_edge[0] > req_edge + 49), 1);

        // timeout on byte 3, then recovery
        clear_logs();
        withhold_at[0] = 3; withhold_at[1] = 3;
        pulse_req();
        for (int k = 0; k < 1000 && !(err_cnt[0] >= 1 && err_cnt[1] >= 1); k++) cycle();
        chk("tmo_err0", err_cnt[0], 1);
        chk("tmo_gap0", err_edge[0] - last_start_edge[0], 100);
        chk("tmo_gap1", err_edge[1] - last_start_edge[1], 100);
        chk("tmo_starts0", start_cnt[0], 3);
        repeat (5) cycle();
        chk("tmo_busy0", int'(if0.busy), 0);
        chk("tmo_no_done0", fd_cnt[0], 0);
        withhold_at[0] = 0; withhold_at[1] = 0;
        clear_logs();
        pulse_req();
        wait_frames("tmo_retry", 1, 1500);
        chk_bytes("tmo_retry0", cap0, exp_a, 0, 13);

        // reset in the middle of byte 7 with a queued request
        clear_logs();
        pulse_req();
        for (int k = 0; k < 1000 && start_cnt[0] < 7; k++) cycle();
        pulse_req();
        reset = 1'b0;
        cycle();
        chk("mid_rst_busy0", int'(if0.busy), 0);
        chk("mid_rst_start0", int'(if0.tx_start), 0);
        chk("mid_rst_data0", int'(if0.tx_data), 0);
        chk("mid_rst_data1", int'(if1.tx_data), 0);
        reset = 1'b1;
        repeat (300) cycle();
        chk("mid_rst_starts0", start_cnt[0], 7);
        chk("mid_rst_starts1", start_cnt[1], 7);
        chk("mid_rst_done0", fd_cnt[0], 0);

        // 00:00:09 on the short-frame instance
        s_hour = '0; s_min = '0; s_sec = 6'd9; s_cs = '0;
        exp_b = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h39, 8'h0D, 8'h0A};
        clear_logs();
        pulse_req();
        wait_frames("short", 1, 1500);
        chk_bytes("short1", cap1, exp_b, 0, 10);

        // out-of-range fields converted digit by digit without clamping
        s_hour = 5'd31; s_min = 6'd63; s_sec = 6'd60; s_cs = 7'd127;
        exp_a = '{8'h33, 8'h31, 8'h3A, 8'h36, 8'h33, 8'h3A, 8'h36, 8'h30,
                  8'h2E, 8'h3C, 8'h37, 8'h0D, 8'h0A};
        clear_logs();
        pulse_req();
        wait_frames("range", 1, 1500);
        chk_bytes("range0", cap0, exp_a, 0, 13);

        // randomized traffic against the reference
        rand_dly  = 1'b1;
        rand_drop = 1'b1;
        for (int k = 0; k < 8000; k++) begin
            s_req  = ($urandom_range(0, 29) == 0);
            s_busy = ($urandom_range(0, 3) == 0);
            s_hour = 5'($urandom);
            s_min  = 6'($urandom);
            s_sec  = 6'($urandom);
            s_cs   = 7'($urandom);
            reset  = ($urandom_range(0, 999) != 0);
            cycle();
        end
        s_req = 1'b0;
        reset = 1'b1;
        repeat (400) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
